// File: rtl/pc_sequencer_if.sv
// Fetch-side control bundle between the PC sequencer and the ID/MEM stages.
// The slave modport is the sequencer; the master modport is the surrounding pipeline.
interface pc_sequencer_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  stall_if;
   logic                  stall_id;
   logic                  id_valid;
   logic                  branch_flag;
   logic [ADDR_WIDTH-1:0] branch_addr;
   logic                  next_inst_delayslot_flag;
   logic                  flush;
   logic [ADDR_WIDTH-1:0] flush_pc;
   logic [ADDR_WIDTH-1:0] pc;
   logic                  fetch_en;
   logic                  id_delayslot;
   logic                  redirect_pending;
   logic                  pc_misalign;

   modport slave (
      input  stall_if, stall_id, id_valid, branch_flag, branch_addr,
             next_inst_delayslot_flag, flush, flush_pc,
      output pc, fetch_en, id_delayslot, redirect_pending, pc_misalign
   );

   modport master (
      output stall_if, stall_id, id_valid, branch_flag, branch_addr,
             next_inst_delayslot_flag, flush, flush_pc,
      input  pc, fetch_en, id_delayslot, redirect_pending, pc_misalign
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner for the 5-stage MIPS core: arbitrates flush, branch
// redirect and sequential fetch, and tracks branch delay slots entering ID.
module pc_sequencer #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'hBFC0_0000
) (
   input  logic           clk,
   input  logic           rst,
   pc_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic [ADDR_WIDTH-1:0] r_target;
   logic                  r_fetch_en;
   logic                  r_id_delayslot;
   logic                  r_redirect_pending;

   logic w_br_acc;
   logic w_id_adv;
   logic w_ds_next;

   assign w_br_acc  = bus.id_valid & ~bus.stall_id & bus.branch_flag;
   assign w_id_adv  = ~bus.stall_id;
   assign w_ds_next = bus.id_valid & bus.next_inst_delayslot_flag;

   // Flush outranks a held branch; a branch seen while already in PEND is dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state            <= BOOT;
         r_pc               <= RESET_PC;
         r_target           <= '0;
         r_fetch_en         <= 1'b0;
         r_id_delayslot     <= 1'b0;
         r_redirect_pending <= 1'b0;
      end else begin
         if (w_id_adv) begin
            r_id_delayslot <= w_ds_next;
         end
         case (r_state)
            BOOT: begin
               r_fetch_en <= 1'b1;
               r_state    <= RUN;
            end
            RUN, PEND: begin
               if (bus.flush) begin
                  r_pc               <= bus.flush_pc;
                  r_target           <= '0;
                  r_redirect_pending <= 1'b0;
                  r_id_delayslot     <= 1'b0;
                  r_state            <= RUN;
               end else if (r_state == PEND) begin
                  if (!bus.stall_if) begin
                     r_pc               <= r_target;
                     r_redirect_pending <= 1'b0;
                     r_state            <= RUN;
                  end
               end else if (w_br_acc) begin
                  if (!bus.stall_if) begin
                     r_pc <= bus.branch_addr;
                  end else begin
                     r_target           <= bus.branch_addr;
                     r_redirect_pending <= 1'b1;
                     r_state            <= PEND;
                  end
               end else if (!bus.stall_if) begin
                  r_pc <= r_pc + ADDR_WIDTH'(4);
               end
            end
            default: begin
               r_state <= BOOT;
            end
         endcase
      end
   end

   assign bus.pc               = r_pc;
   assign bus.fetch_en         = r_fetch_en;
   assign bus.id_delayslot     = r_id_delayslot;
   assign bus.redirect_pending = r_redirect_pending;
   assign bus.pc_misalign      = (r_pc[1:0] != 2'b00) & r_fetch_en;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each step drives one cycle of pipeline
// inputs and compares the registered outputs against hand-computed values.
module tb_pc_sequencer;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   pc_sequencer_if #(.ADDR_WIDTH(32)) bus ();

   pc_sequencer #(
      .ADDR_WIDTH (32),
      .RESET_PC   (32'hBFC0_0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %08h, expected %08h", tag, observed, expected);
      end
   endtask

   // One cycle: drive inputs, confirm no branch is offered while a redirect is held, clock, settle.
   task automatic applyStimulus(input logic sIf, input logic sId, input logic brFlag,
                                input logic [31:0] brAddr, input logic dsFlag,
                                input logic fl, input logic [31:0] flPc);
      bus.stall_if                 = sIf;
      bus.stall_id                 = sId;
      bus.id_valid                 = 1'b1;
      bus.branch_flag              = brFlag;
      bus.branch_addr              = brAddr;
      bus.next_inst_delayslot_flag = dsFlag;
      bus.flush                    = fl;
      bus.flush_pc                 = flPc;
      if (rst) begin
         checkOutput("noBrInPend", {31'b0, bus.redirect_pending & brFlag & ~sId}, 32'h0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic sIf);
      applyStimulus(sIf, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      bus.id_valid = 1'b1;
      idle(1'b0);
      idle(1'b0);
      checkOutput("rstPc", bus.pc, 32'hBFC0_0000);
      checkOutput("rstFetchEn", {31'b0, bus.fetch_en}, 32'h0);
      checkOutput("rstPend", {31'b0, bus.redirect_pending}, 32'h0);
      checkOutput("rstDs", {31'b0, bus.id_delayslot}, 32'h0);

      // Reset release: BOOT cycle, then sequential fetch
      rst = 1'b1;
      idle(1'b0);
      checkOutput("bootPc", bus.pc, 32'hBFC0_0000);
      checkOutput("bootFetchEn", {31'b0, bus.fetch_en}, 32'h1);
      idle(1'b0);
      checkOutput("seqPc1", bus.pc, 32'hBFC0_0004);
      idle(1'b0);
      checkOutput("seqPc2", bus.pc, 32'hBFC0_0008);
      idle(1'b0);
      idle(1'b0);
      checkOutput("seqPc4", bus.pc, 32'hBFC0_0010);

      // Taken branch without fetch stall
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hBFC0_0100, 1'b1, 1'b0, 32'h0);
      checkOutput("brPc", bus.pc, 32'hBFC0_0100);
      checkOutput("brPend", {31'b0, bus.redirect_pending}, 32'h0);
      checkOutput("brDsSet", {31'b0, bus.id_delayslot}, 32'h1);
      idle(1'b0);
      checkOutput("brNextPc", bus.pc, 32'hBFC0_0104);
      checkOutput("brDsClr", {31'b0, bus.id_delayslot}, 32'h0);

      // Branch under a 3-cycle fetch stall
      applyStimulus(1'b1, 1'b0, 1'b1, 32'hBFC0_0200, 1'b1, 1'b0, 32'h0);
      checkOutput("stlPend1", {31'b0, bus.redirect_pending}, 32'h1);
      checkOutput("stlPc1", bus.pc, 32'hBFC0_0104);
      idle(1'b1);
      checkOutput("stlPc2", bus.pc, 32'hBFC0_0104);
      idle(1'b1);
      checkOutput("stlPc3", bus.pc, 32'hBFC0_0104);
      checkOutput("stlPend3", {31'b0, bus.redirect_pending}, 32'h1);
      idle(1'b0);
      checkOutput("stlTgtPc", bus.pc, 32'hBFC0_0200);
      checkOutput("stlPendClr", {31'b0, bus.redirect_pending}, 32'h0);
      idle(1'b0);
      checkOutput("stlAfterPc", bus.pc, 32'hBFC0_0204);

      // Flush wins over a held branch target
      applyStimulus(1'b1, 1'b0, 1'b1, 32'hBFC0_0300, 1'b1, 1'b0, 32'h0);
      checkOutput("flPendSet", {31'b0, bus.redirect_pending}, 32'h1);
      checkOutput("flDsSet", {31'b0, bus.id_delayslot}, 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hBFC0_0380);
      checkOutput("flPc", bus.pc, 32'hBFC0_0380);
      checkOutput("flPendClr", {31'b0, bus.redirect_pending}, 32'h0);
      checkOutput("flDsClr", {31'b0, bus.id_delayslot}, 32'h0);
      idle(1'b0);
      checkOutput("flNextPc", bus.pc, 32'hBFC0_0384);

      // stall_id blocks branch acceptance and holds the delay-slot flag
      applyStimulus(1'b0, 1'b1, 1'b1, 32'hBFC0_0500, 1'b1, 1'b0, 32'h0);
      checkOutput("sidPc1", bus.pc, 32'hBFC0_0388);
      checkOutput("sidDsHold", {31'b0, bus.id_delayslot}, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'hBFC0_0500, 1'b1, 1'b0, 32'h0);
      checkOutput("sidPc2", bus.pc, 32'hBFC0_038C);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hBFC0_0500, 1'b1, 1'b0, 32'h0);
      checkOutput("sidRedirPc", bus.pc, 32'hBFC0_0500);
      checkOutput("sidDsSet", {31'b0, bus.id_delayslot}, 32'h1);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      checkOutput("sidDsHeld", {31'b0, bus.id_delayslot}, 32'h1);
      checkOutput("ifHoldPc", bus.pc, 32'hBFC0_0500);

      // Misaligned target and address wrap
      applyStimulus(1'b0, 1'b0, 1'b1, 32'hBFC0_0102, 1'b0, 1'b0, 32'h0);
      checkOutput("misPc", bus.pc, 32'hBFC0_0102);
      checkOutput("misFlag", {31'b0, bus.pc_misalign}, 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
      checkOutput("wrapTop", bus.pc, 32'hFFFF_FFFC);
      checkOutput("alignFlag", {31'b0, bus.pc_misalign}, 32'h0);
      idle(1'b0);
      checkOutput("wrapPc", bus.pc, 32'h0000_0000);

      // Reset during PEND discards the target; flush ignored in BOOT only
      applyStimulus(1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
      checkOutput("rpPend", {31'b0, bus.redirect_pending}, 32'h1);
      rst = 1'b0;
      idle(1'b1);
      checkOutput("rpRstPc", bus.pc, 32'hBFC0_0000);
      checkOutput("rpRstPend", {31'b0, bus.redirect_pending}, 32'h0);
      checkOutput("rpRstFetch", {31'b0, bus.fetch_en}, 32'h0);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0100);
      checkOutput("bootFlushIgn", bus.pc, 32'hBFC0_0000);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0100);
      checkOutput("postBootFlush", bus.pc, 32'h0000_0100);
      idle(1'b0);
      checkOutput("postBootSeq", bus.pc, 32'h0000_0104);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the 5-stage MIPS core.
- Arbitrates four next-PC sources:
  - reset vector
  - exception/flush vector from the MEM-stage control
  - branch redirect produced by the ID-stage branch resolver
  - sequential PC+4
- Applies the MIPS branch-delay-slot rule.
- Holds a taken branch pending while fetch is stalled.
- Tells ID when the instruction it is about to receive is a delay slot.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC loaded while reset is asserted.
- ADDR_WIDTH, 32, width of all address ports.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-low. Asserted (0) at a rising edge resets all state.
- stall_if  in  1  fetch cannot accept a new PC (instruction memory busy).
- stall_id  in  1  ID stage holding its instruction (load-use or downstream stall).
- id_valid  in  1  ID currently holds a valid instruction.
- branch_flag  in  1  ID resolver: branch/jump taken.
- branch_addr  in  ADDR_WIDTH  ID resolver: target address.
- next_inst_delayslot_flag  in  1  ID resolver: ID holds a branch-class instruction.
- flush  in  1  exception/ERET redirect; highest priority.
- flush_pc  in  ADDR_WIDTH  target for flush.
- pc  out  ADDR_WIDTH  current fetch address (registered).
- fetch_en  out  1  instruction-memory enable (registered).
- id_delayslot  out  1  instruction entering/held in ID is a delay slot (registered).
- redirect_pending  out  1  taken branch latched, waiting for stall_if to drop (registered).
- pc_misalign  out  1  combinational: pc[1:0] != 0 and fetch_en. Consumed by exception logic as AdEL.

Behaviour:
- Reset (rst=0 at edge):
  - pc=RESET_PC, fetch_en=0, id_delayslot=0, redirect_pending=0, pending target=0.
  - State goes to BOOT.
- States: BOOT, RUN, PEND.
  - BOOT: one cycle after reset is released, fetch_en<=1, pc unchanged, goto RUN.
  - RUN: normal sequencing.
  - PEND: taken branch held.
- Qualified branch: br_acc = id_valid & ~stall_id & branch_flag. The target is sampled only under br_acc.
- Next-PC priority each edge (state RUN/PEND), highest first:
  1. flush=1:
     - pc<=flush_pc; pending cleared; id_delayslot<=0; state RUN.
     - flush is ignored in BOOT, but is honoured in the cycle after BOOT.
  2. State PEND:
     - stall_if=1: hold pc.
     - stall_if=0: pc<=pending target, redirect_pending<=0, state RUN.
  3. RUN with br_acc:
     - stall_if=0: pc<=branch_addr. The delay slot (old pc = branch+4) was fetched this cycle.
     - stall_if=1: latch branch_addr into the pending register, redirect_pending<=1, state PEND, pc held.
  4. RUN, stall_if=1: hold pc.
  5. RUN otherwise: pc<=pc+4. Wraps modulo 2^ADDR_WIDTH (32'hFFFF_FFFC+4 -> 0); no carry out.
- Delay-slot tracking:
  - id_delayslot<=1 at the edge where ID advances (~stall_id) past a valid instruction with next_inst_delayslot_flag=1.
  - id_delayslot<=0 at the next ID advance without that condition.
  - Held while stall_id=1; cleared by flush.
- br_acc while already in PEND is impossible by construction (ID holds the delay slot). The first latched target wins and a second br_acc is ignored; the bench asserts this does not occur.
- Latency: branch resolved in ID -> target on pc at the next edge when stall_if=0; fetch is never redirected in the same cycle.
- Reset mid-PEND discards the pending target.

Test Plan:
- Reset release: rst 0->1 -> pc=32'hBFC00000, fetch_en 0 for one cycle, then 1; pc increments to BFC00004, BFC00008 on subsequent cycles.
- Taken branch, no stall: pc=BFC00010 with br_acc, branch_addr=BFC00100 -> next pc=BFC00100, redirect_pending=0. id_delayslot=1 for the instruction after the branch, then 0.
- Branch under fetch stall: br_acc with branch_addr=BFC00200 and stall_if=1 for 3 cycles -> redirect_pending=1, pc held for 3 cycles. pc=BFC00200 on the first edge with stall_if=0, then redirect_pending=0.
- Flush beats pending branch: in PEND, flush=1 with flush_pc=BFC00380 -> pc=BFC00380, redirect_pending=0, id_delayslot=0; old target never appears on pc.
- Stall_id gating: branch_flag=1 with stall_id=1 for 2 cycles -> no redirect, pc held only if stall_if. Redirect occurs on the cycle stall_id drops.
- Misaligned jump and wrap:
  - branch_addr=BFC00102 -> pc=BFC00102, pc_misalign=1.
  - Separately, flush_pc=FFFFFFFC -> next sequential pc=00000000.
